// File: rtl/uart_tx.sv
// uart_tx - serial UART transmitter (8N1 by default) clocked by i_clk.
//
// The divided baud square wave on i_baud is treated as a level: it is
// synchronised (s1, s2), delayed once more (s3), and each rising edge
// becomes a one-cycle bit-period tick. Bytes enter through a valid/ready
// handshake and are shifted out LSB first on the registered o_tx pin.
//
// Parameters:
//   DATA_BITS  data bits per frame (5..9), default 8
//   STOP_BITS  stop bits per frame (1 or 2), default 1
//
// Ports:
//   i_clk    system clock
//   i_rst    synchronous active-high reset
//   i_baud   divider output, asynchronous; one period = one bit time
//   i_data   byte to send, sampled only on acceptance
//   i_valid  i_data is valid
//   o_ready  a byte can be accepted this cycle
//   o_tx     serial line, idles high, registered
//   o_busy   a frame is pending or on the line
//
// Build option:
//   UART_TX_PARITY_EN  when defined, an even-parity bit is sent between the
//                      last data bit and the stop bit(s).

module uart_tx #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_baud,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_tx,
  output logic                 o_busy
);

  localparam int                CNT_W     = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(DATA_BITS - 1);
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  // Tick generation
  logic r_s1;
  logic r_s2;
  logic r_s3;
  logic w_tick;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_baud;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_tick = r_s2 & ~r_s3;

  // Frame state
  state_t                 r_state;
  logic [DATA_BITS-1:0]   r_shift;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic                   r_stop_cnt;
  logic                   r_tx;
  logic                   r_pend;

  state_t                 w_state_nxt;
  logic [DATA_BITS-1:0]   w_shift_nxt;
  logic [CNT_W-1:0]       w_bit_cnt_nxt;
  logic                   w_stop_cnt_nxt;
  logic                   w_tx_nxt;
  logic                   w_pend_nxt;
  logic                   w_accept;
  logic                   w_final_stop;

`ifdef UART_TX_PARITY_EN
  logic                   r_par;
  logic                   w_par_nxt;
`endif

  assign w_final_stop = (r_state == ST_STOP) && (r_stop_cnt == STOP_LAST);

  // During the final stop interval the block can take the next byte, but
  // only one: r_pend records that it already holds one.
  assign o_ready  = (r_state == ST_IDLE) | (w_final_stop & ~r_pend);
  assign o_busy   = (r_state != ST_IDLE);
  assign o_tx     = r_tx;
  assign w_accept = i_valid & o_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_tx       <= 1'b1;
      r_pend     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par      <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_stop_cnt <= w_stop_cnt_nxt;
      r_tx       <= w_tx_nxt;
      r_pend     <= w_pend_nxt;
`ifdef UART_TX_PARITY_EN
      r_par      <= w_par_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_stop_cnt_nxt = r_stop_cnt;
    w_tx_nxt       = r_tx;
    w_pend_nxt     = r_pend;
`ifdef UART_TX_PARITY_EN
    w_par_nxt      = r_par;
`endif

    // Acceptance only happens in IDLE or the final stop interval, where the
    // shift register no longer holds undelivered bits.
    if (w_accept) begin
      w_shift_nxt = i_data;
`ifdef UART_TX_PARITY_EN
      w_par_nxt   = ^i_data;
`endif
    end

    case (r_state)
      ST_IDLE: begin
        w_tx_nxt = 1'b1;
        if (w_accept) begin
          w_state_nxt = ST_WAIT;
        end
      end

      // A tick coinciding with the accept is seen in IDLE and ignored, so
      // the start bit always spans a full tick-to-tick interval.
      ST_WAIT: begin
        if (w_tick) begin
          w_state_nxt = ST_START;
          w_tx_nxt    = 1'b0;
        end
      end

      ST_START: begin
        if (w_tick) begin
          w_state_nxt   = ST_DATA;
          w_tx_nxt      = r_shift[0];
          w_shift_nxt   = {1'b0, r_shift[DATA_BITS-1:1]};
          w_bit_cnt_nxt = '0;
        end
      end

      ST_DATA: begin
        if (w_tick) begin
          if (r_bit_cnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            w_state_nxt    = ST_PARITY;
            w_tx_nxt       = r_par;
`else
            w_state_nxt    = ST_STOP;
            w_tx_nxt       = 1'b1;
            w_stop_cnt_nxt = 1'b0;
`endif
          end else begin
            w_tx_nxt      = r_shift[0];
            w_shift_nxt   = {1'b0, r_shift[DATA_BITS-1:1]};
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (w_tick) begin
          w_state_nxt    = ST_STOP;
          w_tx_nxt       = 1'b1;
          w_stop_cnt_nxt = 1'b0;
        end
      end
`endif

      // An accept that coincides with the closing tick is treated like an
      // accept in IDLE: go through WAIT so its start bit is full length.
      ST_STOP: begin
        if (w_tick) begin
          if (!w_final_stop) begin
            w_stop_cnt_nxt = r_stop_cnt + 1'b1;
          end else if (r_pend) begin
            w_state_nxt = ST_START;
            w_tx_nxt    = 1'b0;
            w_pend_nxt  = 1'b0;
          end else if (w_accept) begin
            w_state_nxt = ST_WAIT;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (w_accept) begin
          w_pend_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_tx_nxt    = 1'b1;
        w_pend_nxt  = 1'b0;
      end
    endcase
  end

endmodule
